csa_accum: RTL and testbench

CSA_ACCUM -- requirements
Module: csa_accum

---
 rtl/csa_accum_if.sv | 28 ++
 rtl/csa_accum.sv | 95 +++++++++
 tb/tb_csa_accum.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_if.sv
// Operand/result handshake bundle for csa_accum.
// master = operand producer and result consumer, slave = the accumulator.
interface csa_accum_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 20,
  parameter int CW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_data;
  logic [CW-1:0]    out_cnt;
  logic             busy;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, busy
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, busy
  );
endinterface

// File: rtl/csa_accum.sv
// Carry-save add/sub accumulator; the sum is resolved CHUNK bits per cycle, so out_valid
// rises AW/CHUNK edges after the last accept. in_ready is low while resolving or holding a result.
module csa_accum #(
  parameter int WIDTH = 16,
  parameter int EXT   = 4,
  parameter int CHUNK = 4,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  csa_accum_if.slave   bus
);
  localparam int AW  = WIDTH + EXT;
  localparam int NCH = AW / CHUNK;   // AW must be a multiple of CHUNK
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   s_vec;
  logic [AW-1:0]   c_vec;
  logic [AW-1:0]   x_vec;
  logic [AW-1:0]   maj_vec;
  logic [AW-1:0]   result;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            rcarry;
  logic            accept;
  int              base;
  logic [CHUNK:0]  chunk_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (bus.in_valid && bus.in_last) state_nxt = RESOLVE;
      RESOLVE: if (idx == IW'(NCH - 1))         state_nxt = DONE;
      DONE:    if (bus.out_ready)               state_nxt = ACCUM;
      default:                                  state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    accept    = (state == ACCUM) && bus.in_valid;
    // Subtraction: add the one's complement here, inject the +1 into C's free LSB.
    x_vec     = bus.in_sub ? ~AW'(bus.in_data) : AW'(bus.in_data);
    maj_vec   = (s_vec & c_vec) | (s_vec & x_vec) | (c_vec & x_vec);
    base      = int'(idx) * CHUNK;
    chunk_sum = {1'b0, s_vec[base +: CHUNK]} + {1'b0, c_vec[base +: CHUNK]}
              + (CHUNK + 1)'(rcarry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_vec  <= '0;
      c_vec  <= '0;
      cnt    <= '0;
      idx    <= '0;
      rcarry <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        s_vec <= s_vec ^ c_vec ^ x_vec;
        c_vec <= (maj_vec << 1) | AW'(bus.in_sub);
        if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
        if (bus.in_last) begin
          idx    <= '0;
          rcarry <= 1'b0;
        end
      end
      if (state == RESOLVE) begin
        result[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
        rcarry                <= chunk_sum[CHUNK];
        idx                   <= idx + IW'(1);
      end
      if (state == DONE && bus.out_ready) begin
        s_vec  <= '0;
        c_vec  <= '0;
        cnt    <= '0;
        result <= '0;
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != ACCUM);
  assign bus.out_data  = result;
  assign bus.out_cnt   = cnt;
endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: directed vector table, reset/hold corner sequences, and random
// transactions checked against a plain modular-arithmetic model.
module tb_csa_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_accum_if #(.WIDTH(16), .AW(20), .CW(8)) bus ();

  csa_accum #(.WIDTH(16), .EXT(4), .CHUNK(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    int          rep;
    logic [15:0] a;
    logic        sa;
    logic [15:0] b;
    logic        sb;
    logic [19:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [15:0] d, input logic s, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    bus.in_last  = last;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'($urandom);
    bus.in_last   = 1'b1;
    bus.out_ready = 1'($urandom);
    @(posedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Called right after the accepting edge of the last operand; returns at a negedge.
  task automatic wait_done(output int lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, bus.in_ready, 1);
    chk({name, "_busy_after"}, bus.busy, 0);
    chk({name, "_out_data_cleared"}, bus.out_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [19:0] exp_sum;
    int          n_ops;
    logic [15:0] d;
    logic        s;

    vecs[0] = '{"add3",      2,   16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 20'h2FFFD, 8'd3};
    vecs[1] = '{"addsub",    1,   16'h0005, 1'b0, 16'h0007, 1'b1, 20'hFFFFE, 8'd2};
    vecs[2] = '{"wrap17",    16,  16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 20'h0FFEF, 8'd17};
    vecs[3] = '{"single",    0,   16'h0000, 1'b0, 16'h1234, 1'b0, 20'h01234, 8'd1};
    vecs[4] = '{"single_sub",0,   16'h0000, 1'b0, 16'h0001, 1'b1, 20'hFFFFF, 8'd1};
    vecs[5] = '{"sub_zero",  0,   16'h0000, 1'b0, 16'h0000, 1'b1, 20'h00000, 8'd1};
    vecs[6] = '{"neg_mix",   1,   16'hFFFF, 1'b1, 16'h0001, 1'b0, 20'hF0002, 8'd2};
    vecs[7] = '{"saturate",  299, 16'h0001, 1'b0, 16'h0001, 1'b0, 20'h0012C, 8'd255};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_cnt",   bus.out_cnt,   0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) op(vecs[i].a, vecs[i].sa, 1'b0);
      op(vecs[i].b, vecs[i].sb, 1'b1);
      wait_done(lat);
      chk({vecs[i].name, "_latency"},  lat,              5);
      chk({vecs[i].name, "_out_data"}, bus.out_data,     vecs[i].exp_data);
      chk({vecs[i].name, "_out_cnt"},  bus.out_cnt,      vecs[i].exp_cnt);
      chk({vecs[i].name, "_in_ready"}, bus.in_ready,     0);
      release_result(vecs[i].name);
    end

    // Hold in DONE with out_ready low while an ignored operand is offered.
    repeat (2) op(16'hFFFF, 1'b0, 1'b0);
    op(16'hFFFF, 1'b0, 1'b1);
    wait_done(lat);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4444;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_data",  bus.out_data,  20'h2FFFD);
      chk("hold_out_cnt",   bus.out_cnt,   3);
      chk("hold_in_ready",  bus.in_ready,  0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    release_result("hold");

    // Reset during the third RESOLVE cycle.
    op(16'h1111, 1'b0, 1'b0);
    op(16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midres_out_valid", bus.out_valid, 0);
    chk("midres_in_ready",  bus.in_ready,  1);
    chk("midres_busy",      bus.busy,      0);
    chk("midres_out_cnt",   bus.out_cnt,   0);
    op(16'h1234, 1'b0, 1'b1);
    wait_done(lat);
    chk("midres_after_latency", lat,          5);
    chk("midres_after_data",    bus.out_data, 20'h01234);
    chk("midres_after_cnt",     bus.out_cnt,  1);

    // Reset while DONE is held.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("done_rst_out_valid", bus.out_valid, 0);
    chk("done_rst_in_ready",  bus.in_ready,  1);
    chk("done_rst_out_data",  bus.out_data,  0);

    // Reset wins over a simultaneous last-operand handshake.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0055;
    bus.in_last  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("rst_prio_cnt",      bus.out_cnt,  0);
    chk("rst_prio_busy",     bus.busy,     0);
    chk("rst_prio_in_ready", bus.in_ready, 1);
    op(16'h0003, 1'b0, 1'b1);
    wait_done(lat);
    chk("rst_prio_next_data", bus.out_data, 20'h00003);
    release_result("rst_prio");

    // Random transactions against a modular-sum model.
    for (int t = 0; t < 25; t++) begin
      n_ops   = $urandom_range(1, 12);
      exp_sum = '0;
      for (int i = 0; i < n_ops; i++) begin
        if ($urandom_range(0, 2) == 0) idle();
        d = 16'($urandom);
        s = 1'($urandom);
        exp_sum = s ? exp_sum - {4'b0, d} : exp_sum + {4'b0, d};
        op(d, s, (i == n_ops - 1));
      end
      wait_done(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("rand_latency", lat,          5);
      chk("rand_valid",   bus.out_valid, 1);
      chk("rand_data",    bus.out_data, exp_sum);
      chk("rand_cnt",     bus.out_cnt,  n_ops);
      release_result("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
